// File: rtl/issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : issue_scoreboard
// Purpose  : In-order issue scoreboard. Tracks every architectural register
//            with an outstanding write and books the single ARF write port
//            cycle by cycle through a result shift register. Produces the
//            Issue/Decode hold and tells the writeback mux who owns the port.
// Ports    : clock, reset (async, active-low)
//            iss_sb_*      - instruction presented at Issue this cycle
//            flush         - synchronous clear of all tracking state
//            sb_iss_stall  - combinational hold (RAW / WAW / port conflict)
//            sb_iss_issue  - combinational, valid & ~stall
//            sb_wb_*       - ARF write owner this cycle (slot 0)
//            sb_pending    - registered per-register busy vector (bit 0 = 0)
// Revision : 1.0 - initial release
// ============================================================================
module issue_scoreboard #(
  parameter int DEPTH   = 8,
  parameter int ALU_LAT = 1,
  parameter int MEM_LAT = 3,
  parameter int MUL_LAT = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iss_sb_valid,
  input  logic [4:0]  iss_sb_addra,
  input  logic [4:0]  iss_sb_addrb,
  input  logic        iss_sb_usea,
  input  logic        iss_sb_useb,
  input  logic        iss_sb_writereg,
  input  logic [4:0]  iss_sb_regdest,
  input  logic [1:0]  iss_sb_fu,
  input  logic        flush,
  output logic        sb_iss_stall,
  output logic        sb_iss_issue,
  output logic        sb_wb_valid,
  output logic [4:0]  sb_wb_regdest,
  output logic [1:0]  sb_wb_fu,
  output logic [31:0] sb_pending
);

  localparam logic [1:0] FU_ALU = 2'b00;
  localparam logic [1:0] FU_MEM = 2'b01;
  localparam logic [1:0] FU_MUL = 2'b10;
  localparam logic [1:0] FU_NONE = 2'b11;

  // Slot k valid means the ARF write happens k cycles from now.
  logic [DEPTH-1:0]      slot_valid_q, slot_valid_d;
  logic [DEPTH-1:0][4:0] slot_reg_q,   slot_reg_d;
  logic [DEPTH-1:0][1:0] slot_fu_q,    slot_fu_d;
  logic [31:0]           pending_q,    pending_d;

  int   lat;
  logic res;
  logic raw;
  logic waw;
  logic port_busy;
  logic stall;
  logic issue;

  always_comb begin
    case (iss_sb_fu)
      FU_ALU:  lat = ALU_LAT;
      FU_MEM:  lat = MEM_LAT;
      FU_MUL:  lat = MUL_LAT;
      default: lat = DEPTH;   // no result; maps to the always-free index
    endcase
  end

  always_comb begin
    res = iss_sb_writereg & (iss_sb_regdest != 5'd0) & (iss_sb_fu != FU_NONE);
    // pending_q[0] is held at 0, so reading r0 never stalls.
    raw = (iss_sb_usea & pending_q[iss_sb_addra]) |
          (iss_sb_useb & pending_q[iss_sb_addrb]);
    waw = res & pending_q[iss_sb_regdest];
    // An index at or beyond DEPTH is treated as a free port slot.
    port_busy = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (k == lat) port_busy = slot_valid_q[k];
    end
    stall = iss_sb_valid & (raw | waw | (res & port_busy));
    issue = iss_sb_valid & ~stall;
  end

  always_comb begin
    // Shift toward slot 0; the top slot refills empty.
    slot_valid_d = {1'b0, slot_valid_q[DEPTH-1:1]};
    slot_reg_d   = {5'd0, slot_reg_q[DEPTH-1:1]};
    slot_fu_d    = {2'b00, slot_fu_q[DEPTH-1:1]};
    pending_d    = pending_q;

    // Slot 0 is committing this cycle, so its register frees at the edge.
    if (slot_valid_q[0]) pending_d[slot_reg_q[0]] = 1'b0;

    // A new reservation lands after the clear so that a set wins.
    if (issue & res) begin
      pending_d[iss_sb_regdest] = 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
        if (k == lat - 1) begin
          slot_valid_d[k] = 1'b1;
          slot_reg_d[k]   = iss_sb_regdest;
          slot_fu_d[k]    = iss_sb_fu;
        end
      end
    end

    if (flush) begin
      slot_valid_d = '0;
      slot_reg_d   = '0;
      slot_fu_d    = '0;
      pending_d    = '0;
    end

    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slot_valid_q <= '0;
      slot_reg_q   <= '0;
      slot_fu_q    <= '0;
      pending_q    <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_reg_q   <= slot_reg_d;
      slot_fu_q    <= slot_fu_d;
      pending_q    <= pending_d;
    end
  end

  assign sb_iss_stall  = stall;
  assign sb_iss_issue  = issue;
  assign sb_wb_valid   = slot_valid_q[0];
  assign sb_wb_regdest = slot_reg_q[0];
  assign sb_wb_fu      = slot_fu_q[0];
  assign sb_pending    = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_issue_scoreboard
// Purpose  : Self-checking bench for issue_scoreboard. Expected writebacks
//            are queued when an instruction is expected to issue and are
//            popped when the write port should carry them. Expected stall
//            and busy vector are derived from that queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_issue_scoreboard;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        v = 1'b0;
  logic [4:0]  a = '0;
  logic [4:0]  b = '0;
  logic        ua = 1'b0;
  logic        ub = 1'b0;
  logic        wr = 1'b0;
  logic [4:0]  dest = '0;
  logic [1:0]  fu = 2'b11;
  logic        fl = 1'b0;
  logic        sb_iss_stall;
  logic        sb_iss_issue;
  logic        sb_wb_valid;
  logic [4:0]  sb_wb_regdest;
  logic [1:0]  sb_wb_fu;
  logic [31:0] sb_pending;

  issue_scoreboard dut (
    .clock           (clock),
    .reset           (reset),
    .iss_sb_valid    (v),
    .iss_sb_addra    (a),
    .iss_sb_addrb    (b),
    .iss_sb_usea     (ua),
    .iss_sb_useb     (ub),
    .iss_sb_writereg (wr),
    .iss_sb_regdest  (dest),
    .iss_sb_fu       (fu),
    .flush           (fl),
    .sb_iss_stall    (sb_iss_stall),
    .sb_iss_issue    (sb_iss_issue),
    .sb_wb_valid     (sb_wb_valid),
    .sb_wb_regdest   (sb_wb_regdest),
    .sb_wb_fu        (sb_wb_fu),
    .sb_pending      (sb_pending)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         c;
    logic [4:0] r;
    logic [1:0] f;
  } wb_t;

  wb_t  sbq[$];
  int   cyc = 0;
  int   nchecks = 0;
  int   nerr = 0;
  bit   last_ei = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: compare at the falling edge, update the model, advance.
  task automatic step();
    bit [31:0]  mp;
    bit         res, raw, waw, port, es, ei;
    int         lat, idx;
    @(negedge clock);
    mp = '0;
    foreach (sbq[i]) mp[sbq[i].r] = 1'b1;
    res = wr && (dest != 5'd0) && (fu != 2'b11);
    lat = (fu == 2'b00) ? 1 : (fu == 2'b01) ? 3 : (fu == 2'b10) ? 5 : 8;
    port = 1'b0;
    foreach (sbq[i]) if (sbq[i].c == cyc + lat) port = 1'b1;
    raw = (ua && mp[a]) || (ub && mp[b]);
    waw = res && mp[dest];
    es  = v && (raw || waw || (res && port));
    ei  = v && !es;
    chk("stall",   {31'd0, sb_iss_stall}, {31'd0, es});
    chk("issue",   {31'd0, sb_iss_issue}, {31'd0, ei});
    chk("pending", sb_pending, mp);
    idx = -1;
    foreach (sbq[i]) if (sbq[i].c == cyc) idx = i;
    if (idx >= 0) begin
      chk("wb_valid", {31'd0, sb_wb_valid}, 32'd1);
      chk("wb_reg",   {27'd0, sb_wb_regdest}, {27'd0, sbq[idx].r});
      chk("wb_fu",    {30'd0, sb_wb_fu}, {30'd0, sbq[idx].f});
      sbq.delete(idx);
    end else begin
      chk("wb_idle", {31'd0, sb_wb_valid}, 32'd0);
    end
    last_ei = ei;
    if (fl) sbq.delete();
    else if (ei && res) sbq.push_back('{c: cyc + lat, r: dest, f: fu});
    @(posedge clock);
    cyc++;
    #1;
  endtask

  task automatic present(input logic [1:0] f, input logic w, input logic [4:0] d,
                         input logic usa, input logic [4:0] ra,
                         input logic usb, input logic [4:0] rb);
    v = 1'b1; fu = f; wr = w; dest = d; ua = usa; a = ra; ub = usb; b = rb;
  endtask

  task automatic idle(input int n);
    v = 1'b0; wr = 1'b0; ua = 1'b0; ub = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  // Hold the current instruction until it issues; report cycles spent.
  task automatic issue_wait(input string tag, input int exp_n);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!last_ei && n < 20);
    chk(tag, n, exp_n);
    v = 1'b0; wr = 1'b0; ua = 1'b0; ub = 1'b0;
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_wb_valid", {31'd0, sb_wb_valid}, 32'd0);
    chk("rst_wb_reg",   {27'd0, sb_wb_regdest}, 32'd0);
    chk("rst_wb_fu",    {30'd0, sb_wb_fu}, 32'd0);
    chk("rst_pending",  sb_pending, 32'd0);
    chk("rst_stall",    {31'd0, sb_iss_stall}, 32'd0);
    chk("rst_issue",    {31'd0, sb_iss_issue}, 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // ALU r3 reading r1: writes back next cycle
    present(2'b00, 1'b1, 5'd3, 1'b1, 5'd1, 1'b0, 5'd0);
    issue_wait("alu_issue", 1);
    #3;
    chk("alu_pend3", {31'd0, sb_pending[3]}, 32'd1);
    chk("alu_wb3",   {27'd0, sb_wb_regdest}, 32'd3);
    idle(2);

    // RAW behind a MUL
    present(2'b10, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
    issue_wait("mul_issue", 1);
    present(2'b00, 1'b1, 5'd6, 1'b0, 5'd0, 1'b1, 5'd5);
    issue_wait("raw_cycles", 6);
    idle(3);

    // Port conflict: MEM r2 then ALU r4 two cycles later
    present(2'b01, 1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 5'd0);
    issue_wait("mem_issue", 1);
    idle(1);
    present(2'b00, 1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 5'd0);
    issue_wait("port_cycles", 2);
    idle(3);

    // WAW on r7
    present(2'b10, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0);
    issue_wait("waw_mul", 1);
    present(2'b00, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0);
    issue_wait("waw_cycles", 6);
    idle(3);

    // r0 writes and fu=11 never reserve and never see the port
    present(2'b01, 1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 5'd0);
    issue_wait("nores_mem", 1);
    idle(1);
    present(2'b00, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0);
    issue_wait("r0_write", 1);
    present(2'b11, 1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 5'd0);
    issue_wait("fu_none", 1);
    idle(3);

    // Back-to-back independent ALU ops
    for (int i = 1; i <= 4; i++) begin
      present(2'b00, 1'b1, 5'(20 + i), 1'b0, 5'd0, 1'b0, 5'd0);
      issue_wait("b2b_alu", 1);
    end
    idle(2);

    // Flush with a MUL in flight; instruction in the flush cycle dropped
    present(2'b10, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0);
    issue_wait("fl_mul", 1);
    idle(1);
    fl = 1'b1;
    present(2'b00, 1'b1, 5'd10, 1'b0, 5'd0, 1'b0, 5'd0);
    issue_wait("fl_cycle_issue", 1);
    fl = 1'b0;
    #3;
    chk("fl_pending", sb_pending, 32'd0);
    idle(7);

    // Async reset with three slots valid
    present(2'b10, 1'b1, 5'd12, 1'b0, 5'd0, 1'b0, 5'd0);
    issue_wait("ar_mul", 1);
    present(2'b01, 1'b1, 5'd13, 1'b0, 5'd0, 1'b0, 5'd0);
    issue_wait("ar_mem", 1);
    present(2'b00, 1'b1, 5'd14, 1'b0, 5'd0, 1'b0, 5'd0);
    issue_wait("ar_alu", 1);
    #1;
    reset = 1'b0;
    #1;
    sbq.delete();
    chk("ar_wb_valid", {31'd0, sb_wb_valid}, 32'd0);
    chk("ar_wb_reg",   {27'd0, sb_wb_regdest}, 32'd0);
    chk("ar_wb_fu",    {30'd0, sb_wb_fu}, 32'd0);
    chk("ar_pending",  sb_pending, 32'd0);
    chk("ar_stall",    {31'd0, sb_iss_stall}, 32'd0);
    #1;
    reset = 1'b1;
    present(2'b00, 1'b1, 5'd15, 1'b1, 5'd12, 1'b1, 5'd13);
    issue_wait("ar_resume", 1);
    idle(3);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/issue_scoreboard.md
# issue_scoreboard

In-order issue scoreboard for the pipeline's Issue stage. It tracks every architectural register with an outstanding write and reserves the single ARF write port cycle-by-cycle through a result shift register. It tells Issue when to stall on RAW, WAW and write-port conflicts (this signal drives Decode's `iss_stall`), and tells the writeback mux which functional unit owns the ARF write port each cycle.

## Interface
- DEPTH, 8: result shift register slots; legal latencies are 1..DEPTH-1
- ALU_LAT, 1: ALU/shift result latency in cycles
- MEM_LAT, 3: load result latency in cycles
- MUL_LAT, 5: multiply/divide result latency in cycles

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low
- iss_sb_valid  in  1  instruction present at Issue this cycle
- iss_sb_addra  in  5  source A register
- iss_sb_addrb  in  5  source B register
- iss_sb_usea  in  1  source A is read
- iss_sb_useb  in  1  source B is read
- iss_sb_writereg  in  1  instruction writes a register
- iss_sb_regdest  in  5  destination register
- iss_sb_fu  in  2  unit select: 00 ALU, 01 MEM, 10 MUL, 11 none (branch/jump/nop; never reserves)
- flush  in  1  synchronous clear of all tracking state
- sb_iss_stall  out  1  combinational hold; Issue and Decode keep their current instruction
- sb_iss_issue  out  1  combinational; equals iss_sb_valid & ~sb_iss_stall
- sb_wb_valid  out  1  ARF write expected this cycle (registered, slot 0)
- sb_wb_regdest  out  5  register being written this cycle
- sb_wb_fu  out  2  unit whose result drives the ARF write port this cycle
- sb_pending  out  32  registered per-register busy vector; bit 0 is always 0

## Operation
- State: pending[31:1], plus slots 0..DEPTH-1, each holding {valid, reg[4:0], fu[1:0]}. Slot k valid in cycle t means the ARF write happens in cycle t+k.
- Latency L comes from iss_sb_fu via ALU_LAT, MEM_LAT or MUL_LAT.
- An instruction reserves only when `res = iss_sb_writereg & (iss_sb_regdest != 0) & (iss_sb_fu != 11)`. Stores and branches never reserve.
- Stall causes (OR'ed, all gated by iss_sb_valid):
  - RAW: (usea & pending[addra]) | (useb & pending[addrb]). Reading register 0 never stalls.
  - WAW: res & pending[regdest].
  - Port conflict: res & slot[L].valid, where slot index L denotes "free" when L ≥ DEPTH.
- Every edge: slot[k] <= slot[k+1] for k < DEPTH-1, and slot[DEPTH-1] <= invalid.
- On issue with res: slot[L-1] <= {1, regdest, fu} (this overrides the shift into that slot), and pending[regdest] <= 1.
- When slot 0 is valid at an edge, pending[slot0.reg] <= 0. This is the cycle the ARF write commits.
- There is no bypass. A consumer stays stalled through the writeback cycle and issues the cycle after it.
- A set and a clear cannot hit the same register on the same edge, because WAW stalls while pending. The RTL still gives set priority.
- flush: all slots invalid and pending all zero at the next edge. An issue in the same cycle is discarded; flush wins.
- sb_wb_* are driven directly from slot 0: valid, reg and fu.

## Timing
- Reset (async, active-low): all slots invalid; pending = 0; sb_wb_valid = 0; sb_wb_regdest = 0; sb_wb_fu = 00; sb_pending = 0. With iss_sb_valid = 0, sb_iss_stall = 0 and sb_iss_issue = 0.
- Reset asserted mid-operation drops all reservations immediately. The write port is free on the first cycle after release.
- Issue in cycle t with latency L gives sb_wb_valid = 1 in cycle t+L. The dependent instruction can issue in cycle t+L+1 at the earliest.
- sb_iss_stall is purely combinational from inputs and current state, with no added cycle.
- Back-to-back ALU instructions with independent destinations issue every cycle. The port is never double-booked.

## Test plan
- Reset, then issue ALU r3 (addra r1) in cycle 0 -> sb_wb_valid=1, regdest=3, fu=00 in cycle 1; sb_pending[3]=1 during cycle 1 only.
- MUL writing r5 in cycle 0, then an ALU reading r5 presented in cycle 1 -> stall for cycles 1-5; sb_iss_issue=1 in cycle 6.
- Port conflict: MEM writing r2 issued in cycle 0 (wb cycle 3), then ALU writing r4 presented in cycle 2 (wb also cycle 3) -> stall in cycle 2, issue in cycle 3, wb r4 in cycle 4.
- WAW: MUL writing r7, then ALU writing r7 the next cycle -> stall until the cycle after r7's writeback. Writes to r0 and fu=11 instructions never reserve and never stall on the port.
- flush asserted in cycle 2 with a MUL writing r9 in flight -> sb_pending=0 and no sb_wb_valid for r9 afterwards. An instruction issued in the flush cycle is not tracked.
- Async reset pulse mid-run with 3 slots valid -> all outputs zero immediately; normal issue resumes on the first edge after release.
